// File: rtl/fsm_serial_pkg.sv
// rtl/fsm_serial_pkg.sv - shared state codes and line levels for the serial FSM blocks
//
// Purpose: state encoding and line levels shared by the serializer and the
//          receiver/detector blocks, plus a counter-width helper.
// Ports:   none (package).

package fsm_serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = IDLE_LEVEL;

  // Width of a counter holding 0..n-1, never less than one bit.
  function automatic int unsigned ctr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - per-bit cycle counter for the serial FSM
//
// Purpose: counts 0..BIT_CYCLES-1 and wraps; tick marks the last cycle of a bit.
// Ports:
//   clk      in  clock
//   reset_n  in  asynchronous active-low reset
//   clear    in  hold the count at 0 (idle / frame start)
//   tick     out high on the last cycle of each bit period

module bit_timer #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);
  import fsm_serial_pkg::*;

  localparam int unsigned     CW   = ctr_width(BIT_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/moore_serializer.sv
// rtl/moore_serializer.sv - framed Moore serial transmitter (start, data MSB first, parity, stop)
//
// Purpose: accepts a WIDTH-bit word on a valid/ready handshake and sends it as
//          start, data MSB first, optional even parity, stop. The line is a pure
//          decode of registered state, so it never follows inputs combinationally.
// Ports:
//   clk         in  clock
//   reset_n     in  asynchronous active-low reset
//   din         in  word to send, sampled only on accept
//   din_valid   in  din holds a word
//   din_ready   out word can be accepted this cycle (IDLE or last STOP cycle)
//   out         out serial line, idles high
//   busy        out frame in progress
//   frame_done  out pulse on the final cycle of STOP

module moore_serializer #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          PARITY_EN  = 1'b1,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             busy,
  output logic             frame_done
);
  import fsm_serial_pkg::*;

  localparam int unsigned   IW       = ctr_width(WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [IW-1:0]    bit_idx;
  logic             parity_bit;
  logic             tick;
  logic             timer_clear;
  logic             accept;

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .tick    (tick)
  );

  assign accept = din_valid && din_ready;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake decode. The timer is held cleared outside the
  // framed states so every frame starts its START bit at count 0, and illegal
  // codes fall back to IDLE.
  always_comb begin
    state_next  = state;
    din_ready   = 1'b0;
    frame_done  = 1'b0;
    timer_clear = 1'b1;
    case (state)
      S_IDLE: begin
        din_ready = 1'b1;
        if (din_valid) state_next = S_START;
      end
      S_START: begin
        timer_clear = 1'b0;
        if (tick) state_next = S_DATA;
      end
      S_DATA: begin
        timer_clear = 1'b0;
        if (tick && (bit_idx == LAST_BIT)) state_next = PARITY_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        timer_clear = 1'b0;
        if (tick) state_next = S_STOP;
      end
      S_STOP: begin
        timer_clear = 1'b0;
        if (tick) begin
          // Accepting here chains the next frame with no idle gap.
          din_ready  = 1'b1;
          frame_done = 1'b1;
          state_next = din_valid ? S_START : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Line level is a function of registered state only.
  always_comb begin
    out = IDLE_LEVEL;
    case (state)
      S_IDLE:   out = IDLE_LEVEL;
      S_START:  out = START_LEVEL;
      S_DATA:   out = shift_reg[WIDTH-1];
      S_PARITY: out = parity_bit;
      S_STOP:   out = STOP_LEVEL;
      default:  out = IDLE_LEVEL;
    endcase
  end

  // The word and its parity are captured once on accept; later din changes
  // cannot reach the frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg  <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
    end else if (accept) begin
      shift_reg  <= din;
      parity_bit <= ^din;
      bit_idx    <= '0;
    end else if ((state == S_DATA) && tick) begin
      shift_reg <= shift_reg << 1;
      bit_idx   <= (bit_idx == LAST_BIT) ? '0 : bit_idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_moore_serializer.sv
// tb/tb_moore_serializer.sv - self-checking bench for moore_serializer

module tb_moore_serializer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic [3:0] din1 = 4'b0;
  logic       valid1 = 1'b0;
  logic       ready1, out1, busy1, done1;

  logic [3:0] din3 = 4'b0;
  logic       valid3 = 1'b0;
  logic       ready3, out3, busy3, done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  moore_serializer #(.WIDTH(4), .PARITY_EN(1'b1), .BIT_CYCLES(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din1),
    .din_valid  (valid1),
    .din_ready  (ready1),
    .out        (out1),
    .busy       (busy1),
    .frame_done (done1)
  );

  moore_serializer #(.WIDTH(4), .PARITY_EN(1'b0), .BIT_CYCLES(3)) dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din3),
    .din_valid  (valid3),
    .din_ready  (ready3),
    .out        (out3),
    .busy       (busy3),
    .frame_done (done3)
  );

  typedef struct {
    logic [3:0] din;
    logic       valid;
    logic       out;
    logic       busy;
    logic       ready;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] d, input logic v, input logic o,
                     input logic b, input logic r, input logic f);
    vec_t x;
    x.din = d; x.valid = v; x.out = o; x.busy = b; x.ready = r; x.done = f;
    tbl.push_back(x);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [17:0] exp3;
    logic [6:0]  exp_rst;

    // Basic frame: 1011 -> 0,1,0,1,1,P=1,stop
    add(4'b1011, 1, 1, 0, 1, 0);
    add(4'b0000, 0, 0, 1, 0, 0);
    add(4'b0000, 0, 1, 1, 0, 0);
    add(4'b0000, 0, 0, 1, 0, 0);
    add(4'b0000, 0, 1, 1, 0, 0);
    add(4'b0000, 0, 1, 1, 0, 0);
    add(4'b0000, 0, 1, 1, 0, 0);
    add(4'b0000, 0, 1, 1, 1, 1);
    add(4'b0000, 0, 1, 0, 1, 0);
    // Back-to-back: 1011 then 0000 with valid held
    add(4'b1011, 1, 1, 0, 1, 0);
    add(4'b0000, 1, 0, 1, 0, 0);
    add(4'b0000, 1, 1, 1, 0, 0);
    add(4'b0000, 1, 0, 1, 0, 0);
    add(4'b0000, 1, 1, 1, 0, 0);
    add(4'b0000, 1, 1, 1, 0, 0);
    add(4'b0000, 1, 1, 1, 0, 0);
    add(4'b0000, 1, 1, 1, 1, 1);
    add(4'b0000, 0, 0, 1, 0, 0);
    add(4'b0000, 0, 0, 1, 0, 0);
    add(4'b0000, 0, 0, 1, 0, 0);
    add(4'b0000, 0, 0, 1, 0, 0);
    add(4'b0000, 0, 0, 1, 0, 0);
    add(4'b0000, 0, 0, 1, 0, 0);
    add(4'b0000, 0, 1, 1, 1, 1);
    add(4'b0000, 0, 1, 0, 1, 0);
    // Isolation: 1001 in flight while din=0110 and valid held
    add(4'b1001, 1, 1, 0, 1, 0);
    add(4'b0110, 1, 0, 1, 0, 0);
    add(4'b0110, 1, 1, 1, 0, 0);
    add(4'b0110, 1, 0, 1, 0, 0);
    add(4'b0110, 1, 0, 1, 0, 0);
    add(4'b0110, 1, 1, 1, 0, 0);
    add(4'b0110, 1, 0, 1, 0, 0);
    add(4'b0110, 1, 1, 1, 1, 1);
    add(4'b1111, 0, 0, 1, 0, 0);
    add(4'b1111, 0, 0, 1, 0, 0);
    add(4'b1111, 0, 1, 1, 0, 0);
    add(4'b1111, 0, 1, 1, 0, 0);
    add(4'b1111, 0, 0, 1, 0, 0);
    add(4'b1111, 0, 0, 1, 0, 0);
    add(4'b1111, 0, 1, 1, 1, 1);
    add(4'b1111, 0, 1, 0, 1, 0);

    // Reset state
    #2;
    chk("rst out", out1, 1'b1);
    chk("rst busy", busy1, 1'b0);
    chk("rst ready", ready1, 1'b1);
    chk("rst done", done1, 1'b0);
    chk("rst out3", out3, 1'b1);
    chk("rst busy3", busy3, 1'b0);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;

    // Idle stability
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle[%0d] out", i), out1, 1'b1);
      chk($sformatf("idle[%0d] busy", i), busy1, 1'b0);
      chk($sformatf("idle[%0d] done", i), done1, 1'b0);
      next_cycle();
    end

    // Table-driven frames
    for (int i = 0; i < tbl.size(); i++) begin
      din1   = tbl[i].din;
      valid1 = tbl[i].valid;
      @(negedge clk);
      chk($sformatf("tbl[%0d] out", i), out1, tbl[i].out);
      chk($sformatf("tbl[%0d] busy", i), busy1, tbl[i].busy);
      chk($sformatf("tbl[%0d] ready", i), ready1, tbl[i].ready);
      chk($sformatf("tbl[%0d] done", i), done1, tbl[i].done);
      next_cycle();
    end
    valid1 = 1'b0;

    // Stretched bits: BIT_CYCLES=3, no parity, 0110
    exp3 = 18'b000_000_111_111_000_111;
    din3 = 4'b0110;
    valid3 = 1'b1;
    @(negedge clk);
    chk("str accept ready", ready3, 1'b1);
    for (int i = 0; i < 18; i++) begin
      next_cycle();
      valid3 = 1'b0;
      din3 = 4'b1001;
      @(negedge clk);
      chk($sformatf("str[%0d] out", i), out3, exp3[17-i]);
      chk($sformatf("str[%0d] busy", i), busy3, 1'b1);
      chk($sformatf("str[%0d] done", i), done3, (i == 17));
      chk($sformatf("str[%0d] ready", i), ready3, (i == 17));
    end
    next_cycle();
    @(negedge clk);
    chk("str end busy", busy3, 1'b0);
    chk("str end out", out3, 1'b1);
    next_cycle();

    // Reset mid-frame during DATA bit 2
    din1 = 4'b1011;
    valid1 = 1'b1;
    next_cycle();
    valid1 = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    chk("mid pre busy", busy1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid rst out", out1, 1'b1);
    chk("mid rst busy", busy1, 1'b0);
    chk("mid rst ready", ready1, 1'b1);
    chk("mid rst done", done1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("mid hold[%0d] done", i), done1, 1'b0);
      chk($sformatf("mid hold[%0d] out", i), out1, 1'b1);
    end
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid rel busy", busy1, 1'b0);
    next_cycle();

    // Fresh frame 1111 after reset: 0,1,1,1,1,P=0,stop
    exp_rst = 7'b0111101;
    din1 = 4'b1111;
    valid1 = 1'b1;
    @(negedge clk);
    chk("post accept ready", ready1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      valid1 = 1'b0;
      @(negedge clk);
      chk($sformatf("post[%0d] out", i), out1, exp_rst[6-i]);
      chk($sformatf("post[%0d] done", i), done1, (i == 6));
    end
    next_cycle();
    @(negedge clk);
    chk("post end busy", busy1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
